// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte streams,
// locking the grant for a whole packet and sequencing load / start / wait-for-done per byte.
module uart_tx_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int GAP_CYCLES     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 uart_tx_start_o,
  output logic [7:0]           uart_tx_data_o,
  input  logic                 uart_tx_done_i,
  output logic                 busy_o,
  output logic                 err_timeout_o,
  output logic [1:0]           dbg_state
);

  localparam int OW = $clog2(N_REQ);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          lock_q, lock_d;
  logic          last_q, last_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_q, rr_d;
  logic [7:0]    data_q, data_d;
  logic [31:0]   cnt_q, cnt_d;

  logic          pick_valid;
  logic [OW-1:0] pick_idx;
  logic [OW:0]   scan_sum;
  logic [OW-1:0] scan_idx;
  logic [OW-1:0] owner_next;
  logic          accept;

  // Candidate selection: the locked owner only, otherwise the first valid from rr_q upward.
  // The loop runs downward so the lowest offset from rr_q is the last (winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    if (lock_q) begin
      pick_valid = req_valid_i[owner_q];
      pick_idx   = owner_q;
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        scan_sum = {1'b0, rr_q} + (OW+1)'(i);
        if (scan_sum >= (OW+1)'(N_REQ)) scan_sum = scan_sum - (OW+1)'(N_REQ);
        scan_idx = scan_sum[OW-1:0];
        if (req_valid_i[scan_idx]) begin
          pick_valid = 1'b1;
          pick_idx   = scan_idx;
        end
      end
    end
  end

  assign owner_next = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    lock_d        = lock_q;
    last_d        = last_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    accept        = 1'b0;
    err_timeout_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          accept  = 1'b1;
          lock_d  = 1'b1;
          owner_d = pick_idx;
          data_d  = req_data_i[{pick_idx, 3'b000} +: 8];
          last_d  = req_last_i[pick_idx];
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A done arriving in the expiry cycle still counts as a normal completion.
        if (uart_tx_done_i) begin
          if (last_q) begin
            lock_d = 1'b0;
            rr_d   = owner_next;
          end
          cnt_d   = '0;
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_timeout_o = 1'b1;
          lock_d        = 1'b0;
          rr_d          = owner_next;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
      owner_q <= '0;
      rr_q    <= '0;
      data_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake: byte k moves when req_valid_i[k] & req_ready_o[k]; ready is one-hot,
  // only in IDLE, and forced low while reset is asserted.
  assign req_ready_o     = (accept && rst_n) ? (ONE << pick_idx) : '0;
  assign grant_o         = lock_q ? (ONE << owner_q) : '0;
  assign uart_tx_start_o = (state_q == S_START);
  assign uart_tx_data_o  = data_q;
  assign busy_o          = (state_q != S_IDLE);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for the per-cycle behaviour plus
// hand-written sequences for packet lock, watchdog, gap and mid-transfer reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic        done = 1'b0;

  logic [1:0]  ready, grant;
  logic        start, busy, err;
  logic [7:0]  txdata;
  logic [1:0]  dbg;
  logic [1:0]  g_ready, g_grant;
  logic        g_start, g_busy, g_err;
  logic [7:0]  g_txdata;
  logic [1:0]  g_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic sb_on = 1'b0;
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(100), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(ready), .grant_o(grant),
    .uart_tx_start_o(start), .uart_tx_data_o(txdata), .uart_tx_done_i(done),
    .busy_o(busy), .err_timeout_o(err), .dbg_state(dbg)
  );

  uart_tx_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(100), .GAP_CYCLES(5)) dut_gap (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_last_i(req_last), .req_ready_o(g_ready), .grant_o(g_grant),
    .uart_tx_start_o(g_start), .uart_tx_data_o(g_txdata), .uart_tx_done_i(done),
    .busy_o(g_busy), .err_timeout_o(g_err), .dbg_state(g_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard on start pulses ----------------
  always @(negedge clk) begin
    if (rst_n && sb_on && start) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_start: got data %0h expected no start at %0t", txdata, $time);
      end else begin
        check("sb_data", {24'h0, txdata}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  valid;
    logic [15:0] data;
    logic [1:0]  last;
    logic        done;
    int          reps;
    logic [14:0] exp;   // {ready, grant, start, txdata, busy, err}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] v, input logic [15:0] d, input logic [1:0] l,
                     input logic dn, input int reps, input logic [1:0] r, input logic [1:0] g,
                     input logic s, input logic [7:0] td, input logic b, input logic e);
    vec_t x;
    x.valid = v; x.data = d; x.last = l; x.done = dn; x.reps = reps;
    x.exp = {r, g, s, td, b, e};
    vecs.push_back(x);
  endtask

  task automatic apply_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        req_valid = vecs[i].valid; req_data = vecs[i].data;
        req_last = vecs[i].last;   done = vecs[i].done;
        #1;
        check($sformatf("%s_row%0d_%0d", tag, i, k),
              {17'h0, ready, grant, start, txdata, busy, err}, {17'h0, vecs[i].exp});
        tick();
      end
    end
    vecs.delete();
    req_valid = '0; done = 1'b0;
  endtask

  // ---------------- global time bound ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks %0d errors", n_checks, n_errors);
    $fatal(1, "time limit");
  end

  initial begin
    logic ok;
    logic [7:0] prev, cur;
    logic [1:0] oh;

    // reset state
    #2;
    check("reset_outputs", {17'h0, ready, grant, start, txdata, busy, err}, 32'h0);
    reset_dut();
    check("post_reset_idle", {17'h0, ready, grant, start, txdata, busy, err}, 32'h0);
    sb_on = 1'b1;

    // single byte from requester 0, done 20 cycles after accept
    exp_q.push_back(8'hA5);
    add(2'b01, 16'h00A5, 2'b01, 1'b0, 1,  2'b01, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(2'b00, 16'h0000, 2'b00, 1'b0, 1,  2'b00, 2'b01, 1'b1, 8'hA5, 1'b1, 1'b0);
    add(2'b00, 16'h0000, 2'b00, 1'b0, 18, 2'b00, 2'b01, 1'b0, 8'hA5, 1'b1, 1'b0);
    add(2'b00, 16'h0000, 2'b00, 1'b1, 1,  2'b00, 2'b01, 1'b0, 8'hA5, 1'b1, 1'b0);
    add(2'b00, 16'h0000, 2'b00, 1'b0, 1,  2'b00, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0);
    apply_vecs("single");

    // round-robin: both valid, every byte last, done 10 cycles after start
    reset_dut();
    prev = 8'h00;
    for (int j = 0; j < 4; j++) begin
      cur = (j % 2 == 0) ? 8'h11 : 8'h22;
      oh  = (j % 2 == 0) ? 2'b01 : 2'b10;
      exp_q.push_back(cur);
      add(2'b11, 16'h2211, 2'b11, 1'b0, 1, oh,    2'b00, 1'b0, prev, 1'b0, 1'b0);
      add(2'b11, 16'h2211, 2'b11, 1'b0, 1, 2'b00, oh,    1'b1, cur,  1'b1, 1'b0);
      add(2'b11, 16'h2211, 2'b11, 1'b0, 9, 2'b00, oh,    1'b0, cur,  1'b1, 1'b0);
      add(2'b11, 16'h2211, 2'b11, 1'b1, 1, 2'b00, oh,    1'b0, cur,  1'b1, 1'b0);
      prev = cur;
    end
    apply_vecs("rr");

    // packet lock: requester 0 sends 01,02,03 while requester 1 waits
    reset_dut();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'h44);
    req_valid = 2'b11; req_data = 16'h4401; req_last = 2'b10;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) begin
        req_valid[0] = 1'b0;
        ok = 1'b1;
        repeat (50) begin
          #1;
          if (ready !== 2'b00 || grant !== 2'b01) ok = 1'b0;
          tick();
        end
        check("lock_stall_blocks_req1", {31'h0, ok}, 32'h1);
        req_valid[0] = 1'b1;
      end
      req_data[7:0] = 8'(b + 1);
      req_last[0]   = (b == 2);
      #1;
      check($sformatf("lock_accept%0d", b), {30'h0, ready}, 32'h1);
      tick();
      #1;
      check($sformatf("lock_start%0d", b), {29'h0, ready, start}, 32'h1);
      tick();
      ok = 1'b1;
      repeat (5) begin
        #1;
        if (ready !== 2'b00) ok = 1'b0;
        tick();
      end
      done = 1'b1;
      #1;
      if (ready !== 2'b00) ok = 1'b0;
      tick();
      done = 1'b0;
      check($sformatf("lock_req1_blocked%0d", b), {31'h0, ok}, 32'h1);
    end
    req_valid[0] = 1'b0;
    #1;
    check("lock_req1_accept_after_done", {28'h0, ready, grant}, 32'h8);
    tick();
    req_valid = 2'b00;
    #1;
    check("lock_req1_start", {21'h0, grant, start, txdata}, {21'h0, 2'b10, 1'b1, 8'h44});
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;

    // watchdog: done withheld, error exactly 100 cycles after the start pulse
    reset_dut();
    exp_q.push_back(8'h5A);
    req_valid = 2'b01; req_data = 16'h005A; req_last = 2'b01;
    tick();
    req_valid = 2'b00;
    #1;
    check("to_start", {31'h0, start}, 32'h1);
    tick();
    ok = 1'b1;
    for (int i = 1; i < 100; i++) begin
      #1;
      if (err !== 1'b0) ok = 1'b0;
      tick();
    end
    check("to_no_early_err", {31'h0, ok}, 32'h1);
    #1;
    check("to_err_pulse", {28'h0, err, busy, grant}, {28'h0, 1'b1, 1'b1, 2'b01});
    tick();
    #1;
    check("to_after", {27'h0, err, busy, grant, start}, 32'h0);
    check("to_state_idle", {30'h0, dbg}, 32'h0);

    // done in the exact expiry cycle: completion, no error
    exp_q.push_back(8'h6B);
    req_valid = 2'b01; req_data = 16'h006B; req_last = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    for (int i = 1; i < 100; i++) tick();
    done = 1'b1;
    #1;
    check("to_done_at_expiry_no_err", {31'h0, err}, 32'h0);
    tick();
    done = 1'b0;
    #1;
    check("to_done_at_expiry_after", {28'h0, err, busy, grant}, 32'h0);

    // gap of 5 cycles on the second instance
    sb_on = 1'b0;
    reset_dut();
    req_valid = 2'b01; req_data = 16'h0077; req_last = 2'b00;
    #1;
    check("gap_first_accept", {30'h0, g_ready}, 32'h1);
    tick();
    #1;
    check("gap_start", {31'h0, g_start}, 32'h1);
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    ok = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      if (g_ready !== 2'b00 || g_busy !== 1'b1) ok = 1'b0;
      tick();
    end
    check("gap_hold_5", {31'h0, ok}, 32'h1);
    #1;
    check("gap_ready_at_d6", {28'h0, g_ready, g_grant}, 32'h5);
    req_valid = 2'b00;
    tick();

    // reset in the middle of WAIT_DONE
    reset_dut();
    sb_on = 1'b1;
    exp_q.push_back(8'h0C);
    req_valid = 2'b01; req_data = 16'h000C; req_last = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    exp_q.push_back(8'hBB);
    req_valid = 2'b10; req_data = 16'hBB00; req_last = 2'b10;
    #1;
    check("rst_pre_accept_req1", {30'h0, ready}, 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    check("rst_in_wait", {30'h0, dbg}, 32'h2);
    req_valid = 2'b11; req_data = 16'hBBCC; req_last = 2'b11;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {17'h0, ready, grant, start, txdata, busy, err}, 32'h0);
    ok = 1'b1;
    repeat (3) begin
      tick();
      if ({ready, grant, start, txdata, busy, err} !== 15'h0) ok = 1'b0;
    end
    check("rst_hold_outputs", {31'h0, ok}, 32'h1);
    exp_q.push_back(8'hCC);
    rst_n = 1'b1;
    #1;
    check("rst_rr_from_zero", {30'h0, ready}, 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check("rst_restart", {21'h0, grant, start, txdata}, {21'h0, 2'b01, 1'b1, 8'hCC});
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();

    check("sb_drain", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single uart_top transmitter between N_REQ byte-stream requesters, for example the RX echo path and a radar-frame dump path. Arbitration is round-robin, and the grant is locked for a whole packet (until the last byte), so packets never interleave. The block sequences every byte as load, then a 1-cycle start pulse, then a wait for the transmitter done pulse. A watchdog recovers if the done pulse never arrives. The block sits between the requesters and uart_top's rs232_tx_start / rs232_tx_data_i / rs232_tx_int.

Parameters:
N_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 1_000_000, clk cycles to wait in WAIT_DONE before abort (32-bit counter)
GAP_CYCLES, 0, idle clk cycles inserted after each completed byte (0 = no GAP state visit)

Ports:
clk  input  1  system clock (uart_top clock domain)
rst_n  input  1  asynchronous, active-low reset
req_valid_i  input  N_REQ  per-requester byte valid
req_data_i  input  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k]
req_last_i  input  N_REQ  byte is last of packet
req_ready_o  output  N_REQ  one-hot handshake; byte k is accepted when valid[k]&ready[k]
grant_o  output  N_REQ  one-hot current/locked owner, 0 when none
uart_tx_start_o  output  1  1-cycle start pulse to uart_top
uart_tx_data_o  output  8  byte to uart_top, held stable from start until next accept
uart_tx_done_i  input  1  1-cycle transmit-complete pulse from uart_top
busy_o  output  1  high in any state except IDLE
err_timeout_o  output  1  1-cycle pulse on watchdog abort

Behaviour:
- Reset (async), all outputs 0: req_ready_o=0, grant_o=0, uart_tx_start_o=0, uart_tx_data_o=8'h00, busy_o=0, err_timeout_o=0.
- Reset internal state: state=IDLE, lock=0, rr_ptr=0, counters=0.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE, unlocked:
  - Scan requesters starting at rr_ptr, ascending with wrap; the first k with valid[k] wins.
  - req_ready_o[k]=1 combinationally in that same cycle.
  - Capture data and last; set grant_o=onehot(k), lock=1, owner=k; go to START.
- IDLE, locked:
  - Only the owner is considered. Other requesters stall even if the owner's valid is low; the packet is atomic.
- START:
  - uart_tx_start_o=1 for exactly one cycle, with uart_tx_data_o already valid.
  - Clear the timeout counter; go to WAIT_DONE.
  - Latency: accept at cycle T, start pulse at T+1.
- WAIT_DONE:
  - Increment the timeout counter each cycle.
  - On uart_tx_done_i:
    - If the captured last=1: lock=0, grant_o=0, rr_ptr=(owner+1) mod N_REQ.
    - Go to GAP if GAP_CYCLES>0, else IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1 without done:
    - err_timeout_o=1 for one cycle.
    - lock=0, grant_o=0, rr_ptr=(owner+1) mod N_REQ; go to IDLE.
    - The rest of the packet is not flushed; the requester restarts it.
  - Done and timeout in the same cycle: done wins, no error.
- GAP: count GAP_CYCLES cycles, then go to IDLE. The lock is retained if the packet is unfinished.
- uart_tx_done_i outside WAIT_DONE is ignored.
- Earliest next accept, with done at cycle D and GAP_CYCLES=0: D+1. This gives a minimum of 3 cycles per byte excluding serialization.
- At most one bit of req_ready_o is high, and only in IDLE.
- uart_tx_start_o is never asserted twice without an intervening done or timeout.
- Reset mid-operation: immediate return to reset values. Any in-flight uart_top frame is the caller's concern, since uart_top shares rst_n.

Test Plan:
- Single byte: valid[0]=1, data=8'hA5, last=1 at T:
  - ready[0]=1 at T; start pulse at T+1 with data=8'hA5.
  - Done at T+20, then busy_o=0 at T+21 and grant_o=0.
- Round-robin, N_REQ=2: both valid continuously, each byte last=1, done returned 10 cycles after start:
  - Grants alternate 0,1,0,1 with data 8'h11,8'h22,8'h11,8'h22.
- Packet lock: requester 0 sends a 3-byte packet (8'h01,8'h02,8'h03, last on the third); requester 1 is valid throughout:
  - Requester 1 gets no ready until the done of 8'h03.
  - Requester 1's byte is accepted the cycle after that done.
  - Also verify the stall: requester 0 drops valid for 50 cycles mid-packet; requester 1 stays blocked.
- Timeout, TIMEOUT_CYCLES=100: done withheld:
  - err_timeout_o pulses exactly once, 100 cycles after the start pulse.
  - grant_o=0 and state returns to IDLE.
  - Done in the exact expiry cycle gives no err pulse.
- Gap, GAP_CYCLES=5: back-to-back bytes from one requester:
  - Next ready is asserted exactly 6 cycles after done.
- Reset mid-WAIT_DONE: rst_n low for 3 cycles:
  - All outputs 0 asynchronously.
  - After release, a new valid is accepted from rr_ptr=0 with a correct start pulse.
